// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds the four digit registers from a time-multiplexed
// {active-low anode, digit} scan bus. It also flags blanking, illegal anode
// patterns and completed scan frames.
//
// Latency: a pair applied after edge k is registered at edge k+1 and written
// to digits at edge k+STABLE_CYC.
//
// Backpressure: none. The scan driver cannot be stalled; every cycle is
// observed (or only ghost_in=1 cycles when the ghost phase is enabled).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   dig_in       multiplexed digit value
//   anode_in     active-low anode select, bit3=A(MSD) .. bit0=D(LSD)
//   ghost_in     segment-enable phase (only when SEG_SCAN_GHOST_EN is defined)
//   digits       captured digits, A in the top DIG_W bits .. D in the bottom
//   digit_vld    per-position "captured since reset"
//   frame_done   one-cycle pulse per completed frame
//   blank        display currently blanked
//   anode_err    one-cycle pulse when an illegal anode pattern is accepted
//
// Optional feature macro: SEG_SCAN_GHOST_EN (adds ghost_in; sampling is
// gated to ghost_in=1 cycles).
module seg_scan_capture #(
  parameter int         DIG_W      = 3,
  parameter int         STABLE_CYC = 4,
  parameter int         BLANK_CYC  = 1024,
  parameter logic [3:0] FRAME_MASK = 4'b0111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIG_W-1:0]   dig_in,
  input  logic [3:0]         anode_in,
`ifdef SEG_SCAN_GHOST_EN
  input  logic               ghost_in,
`endif
  output logic [4*DIG_W-1:0] digits,
  output logic [3:0]         digit_vld,
  output logic               frame_done,
  output logic               blank,
  output logic               anode_err
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int BLK_W = $clog2(BLANK_CYC + 1);

  logic [3:0]       smp_anode;
  logic [DIG_W-1:0] smp_dig;
  logic [CNT_W-1:0] stab_cnt;
  logic [BLK_W-1:0] blank_cnt;
  logic [3:0]       seen;

  logic       sample_en;
  logic       same;
  logic       accept;
  logic [3:0] anode_on;
  logic       one_hot;
  logic       all_off;
  logic [3:0] hit;
  logic [3:0] seen_nxt;
  logic       frame_cmp;
  logic       blank_hit;

`ifdef SEG_SCAN_GHOST_EN
  // The shadow phase is invisible: smp, the stability count and the blank
  // count all freeze, so it cannot break a stable run.
  assign sample_en = ghost_in;
`else
  assign sample_en = 1'b1;
`endif

  // The stability count tracks the pair that is about to be registered
  // against the pair already held in smp. Accept therefore happens on the
  // edge that moves the count from STABLE_CYC-1 to STABLE_CYC, and the
  // incoming pair (equal to smp) is written on that same edge.
  assign same   = (anode_in == smp_anode) && (dig_in == smp_dig);
  assign accept = sample_en && same && (stab_cnt == CNT_W'(STABLE_CYC - 1));

  assign anode_on = ~anode_in;
  assign one_hot  = (anode_on != 4'b0000) && ((anode_on & (anode_on - 4'd1)) == 4'b0000);
  assign all_off  = (anode_in == 4'b1111);

  assign hit       = (accept && one_hot) ? anode_on : 4'b0000;
  assign seen_nxt  = seen | hit;
  assign frame_cmp = (hit != 4'b0000) && ((seen_nxt & FRAME_MASK) == FRAME_MASK);

  // Blank is entered on the edge where the off-count would reach BLANK_CYC.
  assign blank_hit = sample_en && (smp_anode == 4'b1111) &&
                     (blank_cnt == BLK_W'(BLANK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_anode  <= 4'b1111;
      smp_dig    <= '0;
      stab_cnt   <= '0;
      blank_cnt  <= '0;
      seen       <= 4'b0000;
      digits     <= '0;
      digit_vld  <= 4'b0000;
      frame_done <= 1'b0;
      blank      <= 1'b0;
      anode_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      anode_err  <= 1'b0;

      if (sample_en) begin
        smp_anode <= anode_in;
        smp_dig   <= dig_in;
        if (same) begin
          if (stab_cnt != CNT_W'(STABLE_CYC))
            stab_cnt <= stab_cnt + CNT_W'(1);
        end else begin
          stab_cnt <= CNT_W'(1);
        end

        if (smp_anode == 4'b1111) begin
          if (blank_cnt != BLK_W'(BLANK_CYC))
            blank_cnt <= blank_cnt + BLK_W'(1);
        end else begin
          blank_cnt <= '0;
        end
      end

      for (int i = 0; i < 4; i++) begin
        if (hit[i])
          digits[i*DIG_W +: DIG_W] <= dig_in;
      end

      if (hit != 4'b0000) begin
        digit_vld <= digit_vld | hit;
        blank     <= 1'b0;
        // The completing accept is not carried into the next frame.
        seen      <= frame_cmp ? 4'b0000 : seen_nxt;
        frame_done <= frame_cmp;
      end else if (accept && !all_off) begin
        anode_err <= 1'b1;
      end

      // A one-hot accept needs a one-hot smp, which keeps blank_cnt at zero.
      // So this can never collide with the seen update above.
      if (blank_hit) begin
        blank <= 1'b1;
        seen  <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with the default parameters
// (DIG_W=3, STABLE_CYC=4, BLANK_CYC=1024, FRAME_MASK=0111).
// Digit layout: A[11:9] B[8:6] C[5:3] D[2:0].
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  dig;
  logic [3:0]  anode;
  logic        ghost;
  logic [11:0] digits;
  logic [3:0]  digit_vld;
  logic        frame_done;
  logic        blank;
  logic        anode_err;

  always #5 clk = ~clk;

  seg_scan_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dig_in     (dig),
    .anode_in   (anode),
`ifdef SEG_SCAN_GHOST_EN
    .ghost_in   (ghost),
`endif
    .digits     (digits),
    .digit_vld  (digit_vld),
    .frame_done (frame_done),
    .blank      (blank),
    .anode_err  (anode_err)
  );

  typedef struct {
    logic [3:0]  anode;
    logic [2:0]  dig;
    int          cyc;
    logic [11:0] exp_digits;
    logic [3:0]  exp_vld;
    int          exp_frames;
    int          exp_errs;
    logic        exp_blank;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int nf;
  int ne;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 time unit after the edge,
  // and pulses seen on that edge are accumulated into the counters.
  task automatic step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) nf++;
    if (anode_err === 1'b1) ne++;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    anode = v.anode;
    dig   = v.dig;
    nf    = 0;
    ne    = 0;
    repeat (v.cyc) step();
    chk({name, "_digits"}, {20'd0, digits}, {20'd0, v.exp_digits});
    chk({name, "_vld"},    {28'd0, digit_vld}, {28'd0, v.exp_vld});
    chk({name, "_frames"}, nf, v.exp_frames);
    chk({name, "_errs"},   ne, v.exp_errs);
    chk({name, "_blank"},  {31'd0, blank}, {31'd0, v.exp_blank});
  endtask

  vec_t tbl[12];
  vec_t post[3];

  initial begin
    // Glitch, three-position scan, a second frame from scratch, an illegal
    // pattern, an out-of-mask position, then an idle period and a D capture.
    tbl[0]  = '{4'b1101, 3'd3, 3, 12'h140, 4'b0100, 0, 0, 1'b0};
    tbl[1]  = '{4'b1101, 3'd2, 6, 12'h150, 4'b0110, 0, 0, 1'b0};
    tbl[2]  = '{4'b1011, 3'd4, 8, 12'h110, 4'b0110, 0, 0, 1'b0};
    tbl[3]  = '{4'b1101, 3'd0, 8, 12'h100, 4'b0110, 0, 0, 1'b0};
    tbl[4]  = '{4'b1110, 3'd0, 8, 12'h100, 4'b0111, 1, 0, 1'b0};
    tbl[5]  = '{4'b1101, 3'd7, 8, 12'h138, 4'b0111, 0, 0, 1'b0};
    tbl[6]  = '{4'b1110, 3'd1, 8, 12'h139, 4'b0111, 0, 0, 1'b0};
    tbl[7]  = '{4'b1011, 3'd4, 8, 12'h139, 4'b0111, 1, 0, 1'b0};
    tbl[8]  = '{4'b0011, 3'd6, 8, 12'h139, 4'b0111, 0, 1, 1'b0};
    tbl[9]  = '{4'b0111, 3'd3, 8, 12'h739, 4'b1111, 0, 0, 1'b0};
    tbl[10] = '{4'b1111, 3'd0, 4, 12'h739, 4'b1111, 0, 0, 1'b0};
    tbl[11] = '{4'b1110, 3'd2, 8, 12'h73a, 4'b1111, 0, 0, 1'b0};

    // After a mid-frame reset, a complete D,B,C frame is needed.
    post[0] = '{4'b1110, 3'd3, 8, 12'h003, 4'b0001, 0, 0, 1'b0};
    post[1] = '{4'b1011, 3'd1, 8, 12'h043, 4'b0101, 0, 0, 1'b0};
    post[2] = '{4'b1101, 3'd1, 8, 12'h04b, 4'b0111, 1, 0, 1'b0};

    rst_n = 1'b0;
    anode = 4'b1111;
    dig   = 3'd0;
    ghost = 1'b1;
    nf    = 0;
    ne    = 0;
    repeat (3) step();
    chk("rst_digits", {20'd0, digits}, 32'd0);
    chk("rst_vld", {28'd0, digit_vld}, 32'd0);
    chk("rst_pulses", {30'd0, frame_done, anode_err}, 32'd0);
    chk("rst_blank", {31'd0, blank}, 32'd0);
    rst_n = 1'b1;

    // Latency: B=5 appears on exactly the 4th edge after it is applied.
    anode = 4'b1011;
    dig   = 3'd5;
    repeat (3) step();
    chk("lat_before_digits", {20'd0, digits}, 32'h000);
    chk("lat_before_vld", {28'd0, digit_vld}, 32'd0);
    step();
    chk("lat_at_digits", {20'd0, digits}, 32'h140);
    chk("lat_at_vld", {28'd0, digit_vld}, 32'b0100);
    repeat (6) step();
    chk("hold_frames", nf, 0);
    chk("hold_errs", ne, 0);

    for (int i = 0; i < 12; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // Blank entry: smp sees all-off from edge 1, so count reaches 1024 at edge 1025.
    anode = 4'b1111;
    dig   = 3'd0;
    nf    = 0;
    repeat (1024) step();
    chk("blank_early", {31'd0, blank}, 32'd0);
    step();
    chk("blank_on", {31'd0, blank}, 32'd1);
    repeat (75) step();
    chk("blank_held", {31'd0, blank}, 32'd1);
    chk("blank_frames", nf, 0);
    anode = 4'b1011;
    dig   = 3'd5;
    repeat (3) step();
    chk("unblank_before_blank", {31'd0, blank}, 32'd1);
    chk("unblank_before_digits", {20'd0, digits}, 32'h73a);
    step();
    chk("unblank_blank", {31'd0, blank}, 32'd0);
    chk("unblank_digits", {20'd0, digits}, 32'h77a);
    repeat (4) step();

    // Partial frame B,C, then asynchronous reset between edges.
    run_vec('{4'b1101, 3'd1, 8, 12'h74a, 4'b1111, 0, 0, 1'b0}, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_digits", {20'd0, digits}, 32'd0);
    chk("arst_vld", {28'd0, digit_vld}, 32'd0);
    chk("arst_flags", {29'd0, frame_done, anode_err, blank}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      run_vec(post[i], $sformatf("post%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
